// File: rtl/led_blink_gen.sv
// Multi-channel LED blinker: per-channel ON/OFF phase lengths, level enable, tick at each ON start.
// Optional BLINK_SYNC_EN macro adds i_sync, which realigns every enabled channel to an ON-phase start.
module led_blink_gen #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 24
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  input  logic [CHANNELS-1:0] i_enable,
  input  logic                i_wr_en,
  input  logic [3:0]          i_wr_chan,
  input  logic [CNT_W-1:0]    i_wr_on,
  input  logic [CNT_W-1:0]    i_wr_off,
`ifdef BLINK_SYNC_EN
  input  logic                i_sync,
`endif
  output logic [CHANNELS-1:0] o_led,
  output logic [CHANNELS-1:0] o_tick
);

  typedef enum logic [1:0] {IDLE, ON, OFF} state_t;

  // Reset asserts asynchronously but releases through two flops, so logic runs from the third edge on.
  logic [1:0] rst_sync;
  logic       run;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) rst_sync <= '0;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  logic sync_req;
`ifdef BLINK_SYNC_EN
  assign sync_req = i_sync;
`else
  assign sync_req = 1'b0;
`endif

  logic wr_hit;
  assign wr_hit = run && i_wr_en && ({28'd0, i_wr_chan} < 32'(CHANNELS));

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [CNT_W-1:0] on_len;
    logic [CNT_W-1:0] off_len;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    state_t           state;
    state_t           state_nxt;
    logic             led_q;
    logic             tick_q;
    logic             led_nxt;
    logic             tick_nxt;
    logic             prefer_on;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        on_len  <= '0;
        off_len <= '0;
      end else if (wr_hit && (i_wr_chan == 4'(c))) begin
        on_len  <= i_wr_on;
        off_len <= i_wr_off;
      end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
        state  <= IDLE;
        cnt    <= '0;
        led_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (run) begin
        state  <= state_nxt;
        cnt    <= cnt_nxt;
        led_q  <= led_nxt;
        tick_q <= tick_nxt;
      end
    end

    // cnt holds the cycles left in the current phase; a load happens when it reaches 1 or on restart.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      led_nxt   = 1'b0;
      tick_nxt  = 1'b0;
      prefer_on = 1'b1;
      if (!i_enable[c]) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else if (!sync_req && (state != IDLE) && (cnt > CNT_W'(1))) begin
        cnt_nxt = cnt - CNT_W'(1);
        led_nxt = (state == ON);
      end else begin
        prefer_on = sync_req || (state != ON);
        if ((on_len != '0) && (prefer_on || (off_len == '0))) begin
          state_nxt = ON;
          cnt_nxt   = on_len;
          led_nxt   = 1'b1;
          tick_nxt  = 1'b1;
        end else if (off_len != '0) begin
          state_nxt = OFF;
          cnt_nxt   = off_len;
        end else begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
    end

    assign o_led[c]  = led_q;
    assign o_tick[c] = tick_q;
  end

endmodule

// File: tb/tb_led_blink_gen.sv
// Self-checking bench for led_blink_gen: vector table, directed corner sequences, random run vs phase-queue model.
module tb_led_blink_gen;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic           clk;
  logic           rst_n;
  logic [NCH-1:0] en;
  logic           wr_en;
  logic [3:0]     wr_chan;
  logic [CW-1:0]  wr_on;
  logic [CW-1:0]  wr_off;
  logic           sync_s;
  logic [NCH-1:0] led;
  logic [NCH-1:0] tick;

  int n_tests = 0;
  int n_fail  = 0;

  led_blink_gen #(.CHANNELS(NCH), .CNT_W(CW)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_enable  (en),
    .i_wr_en   (wr_en),
    .i_wr_chan (wr_chan),
    .i_wr_on   (wr_on),
    .i_wr_off  (wr_off),
`ifdef BLINK_SYNC_EN
    .i_sync    (sync_s),
`endif
    .o_led     (led),
    .o_tick    (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each phase is expanded into a queue of {led,tick} cycles when it starts.
  logic [1:0] exp_q [NCH][$];
  int         m_on  [NCH];
  int         m_off [NCH];
  bit         next_on [NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      exp_q[c].delete();
      next_on[c] = 1'b1;
      m_on[c]    = 0;
      m_off[c]   = 0;
    end
  endtask

  task automatic model_refill(input int c);
    for (int k = 0; k < 2 && exp_q[c].size() == 0; k++) begin
      int len;
      len = next_on[c] ? m_on[c] : m_off[c];
      for (int i = 0; i < len; i++) exp_q[c].push_back({next_on[c], next_on[c] && (i == 0)});
      next_on[c] = !next_on[c];
    end
    if (exp_q[c].size() == 0) next_on[c] = 1'b1;
  endtask

  // Steps model with the inputs currently driven, clocks the DUT, then compares.
  task automatic apply_cycle();
    logic [NCH-1:0] el;
    logic [NCH-1:0] et;
    logic [1:0]     e;
    el = '0;
    et = '0;
    for (int c = 0; c < NCH; c++) begin
      if (!en[c]) begin
        exp_q[c].delete();
        next_on[c] = 1'b1;
      end else begin
        if (sync_s) begin
          exp_q[c].delete();
          next_on[c] = 1'b1;
        end
        if (exp_q[c].size() == 0) model_refill(c);
        if (exp_q[c].size() > 0) begin
          e = exp_q[c].pop_front();
          el[c] = e[1];
          et[c] = e[0];
        end
      end
    end
    if (wr_en && int'(wr_chan) < NCH) begin
      m_on[wr_chan]  = int'(wr_on);
      m_off[wr_chan] = int'(wr_off);
    end
    @(posedge clk);
    #1;
    check("model_led", 32'(led), 32'(el));
    check("model_tick", 32'(tick), 32'(et));
  endtask

  task automatic write_cfg(input int ch, input int on, input int off);
    wr_en   = 1'b1;
    wr_chan = 4'(ch);
    wr_on   = CW'(on);
    wr_off  = CW'(off);
    apply_cycle();
    wr_en = 1'b0;
  endtask

  typedef struct {
    logic [NCH-1:0] en;
    logic           wr;
    logic [3:0]     ch;
    logic [CW-1:0]  on;
    logic [CW-1:0]  off;
    logic [NCH-1:0] led;
    logic [NCH-1:0] tick;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int             cnt;
    logic [10:0]    seq;
    logic           ok;

    rst_n = 1'b0; en = '0; wr_en = 1'b0; wr_chan = '0; wr_on = '0; wr_off = '0; sync_s = 1'b0;
    model_reset();

    // Vector table: ch0 on=3 off=2 and ch1 on=4 off=0 from a common enable edge.
    tbl[0] = '{en: 4'b0000, wr: 1'b1, ch: 4'd0, on: 8'd3, off: 8'd2, led: 4'b0000, tick: 4'b0000};
    tbl[1] = '{en: 4'b0000, wr: 1'b1, ch: 4'd1, on: 8'd4, off: 8'd0, led: 4'b0000, tick: 4'b0000};
    for (int r = 2; r < 14; r++) begin
      int k;
      k = r - 2;
      tbl[r].en   = 4'b0011;
      tbl[r].wr   = 1'b0;
      tbl[r].ch   = '0;
      tbl[r].on   = '0;
      tbl[r].off  = '0;
      tbl[r].led  = {2'b00, 1'b1, 1'((k % 5) < 3)};
      tbl[r].tick = {2'b00, 1'((k % 4) == 0), 1'((k % 5) == 0)};
    end

    #3;
    check("reset_led", 32'(led), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) apply_cycle();

    for (int i = 0; i < 14; i++) begin
      en      = tbl[i].en;
      wr_en   = tbl[i].wr;
      wr_chan = tbl[i].ch;
      wr_on   = tbl[i].on;
      wr_off  = tbl[i].off;
      apply_cycle();
      wr_en = 1'b0;
      check($sformatf("vec%0d_led", i), 32'(led), 32'(tbl[i].led));
      check($sformatf("vec%0d_tick", i), 32'(tick), 32'(tbl[i].tick));
    end

    // ch1 rewritten to on=0 off=4: once the running ON ends it stays dark with no tick.
    write_cfg(1, 0, 4);
    for (int i = 0; i < 5; i++) apply_cycle();
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_cycle();
      if (led[1] || tick[1]) ok = 1'b0;
    end
    check("ch1_dark_on0", 32'(ok), 32'd1);

    // Write during ON: current ON keeps 3 cycles, following ON lasts 5.
    en = '0;
    apply_cycle();
    en = 4'b0001;
    apply_cycle();
    check("wr_mid_first", 32'({led[0], tick[0]}), 32'd3);
    write_cfg(0, 5, 2);
    check("wr_mid_second", 32'(led[0]), 32'd1);
    seq = 11'b10011111001;
    for (int i = 0; i < 11; i++) begin
      apply_cycle();
      check($sformatf("wr_mid_seq%0d", i), 32'(led[0]), 32'(seq[10 - i]));
    end

    // Enable dropped mid-ON returns to IDLE; re-enable starts a fresh full ON phase.
    en = '0;
    write_cfg(2, 4, 3);
    en = 4'b0100;
    apply_cycle();
    apply_cycle();
    check("en2_on", 32'(led[2]), 32'd1);
    en = '0;
    apply_cycle();
    check("en2_drop", 32'({led[2], tick[2]}), 32'd0);
    apply_cycle();
    check("en2_stay", 32'(led[2]), 32'd0);
    en = 4'b0100;
    apply_cycle();
    check("en2_restart", 32'({led[2], tick[2]}), 32'd3);
    for (int i = 0; i < 3; i++) apply_cycle();
    check("en2_full_on", 32'(led[2]), 32'd1);
    apply_cycle();
    check("en2_off", 32'(led[2]), 32'd0);

    // Maximum phase length without wrap.
    en = '0;
    write_cfg(3, 255, 1);
    en = 4'b1000;
    apply_cycle();
    cnt = 1;
    for (int g = 0; g < 300; g++) begin
      apply_cycle();
      if (led[3]) cnt++;
      else break;
    end
    check("max_on_len", 32'(cnt), 32'd255);
    apply_cycle();
    check("max_wrap_tick", 32'({led[3], tick[3]}), 32'd3);

`ifdef BLINK_SYNC_EN
    en = '0;
    write_cfg(0, 3, 2);
    write_cfg(1, 2, 6);
    en = 4'b0001;
    apply_cycle(); apply_cycle(); apply_cycle();
    en = 4'b0011;
    apply_cycle(); apply_cycle();
    sync_s = 1'b1;
    apply_cycle();
    sync_s = 1'b0;
    check("sync_tick", 32'(tick[1:0]), 32'd3);
    apply_cycle();
    check("sync_led_a", 32'(led[1:0]), 32'd3);
    apply_cycle();
    check("sync_led_b", 32'(led[1:0]), 32'd1);
`endif

    // Asynchronous reset mid-OFF clears everything at once and discards configuration.
    en = '0;
    write_cfg(0, 3, 2);
    write_cfg(1, 4, 0);
    en = 4'b0011;
    for (int i = 0; i < 4; i++) apply_cycle();
    check("pre_reset_led", 32'(led[1:0]), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_led", 32'(led), 32'd0);
    check("async_reset_tick", 32'(tick), 32'd0);
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    en = '0;
    for (int i = 0; i < 3; i++) apply_cycle();

    // Out-of-range write index leaves every channel unconfigured and dark.
    write_cfg(9, 3, 2);
    en = 4'b1111;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      apply_cycle();
      if (led != '0 || tick != '0) ok = 1'b0;
    end
    check("chan9_ignored", 32'(ok), 32'd1);

    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 15) == 0) en[c] = ~en[c];
      wr_en   = ($urandom_range(0, 5) == 0);
      wr_chan = 4'($urandom_range(0, 15));
      wr_on   = CW'($urandom_range(0, 5));
      wr_off  = CW'($urandom_range(0, 5));
`ifdef BLINK_SYNC_EN
      sync_s = ($urandom_range(0, 19) == 0);
`endif
      apply_cycle();
    end
    wr_en  = 1'b0;
    sync_s = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
